sbox_round_core: RTL and testbench

Iterative 128-bit toy block cipher used as the power-analysis target on the CW305 crypto clock domain. It sits between the register block and the trigger output, and has the same load/busy handshake as the existing XOR core. It latches key and plaintext on a load request and runs pROUNDS nibble-S-box/rotate/XOR rounds, one per cycle. It then presents the ciphertext and a done pulse; busy_o drives the scope trigger.

---
 rtl/sbox_round_core.sv | 122 ++++++++++++
 tb/tb_sbox_round_core.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_round_core.sv
`default_nettype none
// ============================================================================
// Module   : sbox_round_core
// Purpose  : Iterative 128-bit toy block cipher (PRESENT nibble S-box,
//            8-bit left rotate, round-key XOR), one round per clock.
//            Load/busy handshake; busy_o doubles as the scope trigger.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_round_core #(
  parameter int pROUNDS = 10  // legal range 1..15 (round counter is 4 bits)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [3:0]   round_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Round index on which the final round executes.
  localparam logic [3:0] LAST_RND = 4'(pROUNDS);

  logic [0:0]   fsm_q,   fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q,  rkey_d;
  logic [3:0]   rnd_q,   rnd_d;
  logic [127:0] data_q,  data_d;
  logic         done_q,  done_d;

  logic [127:0] sbox_out;
  logic [127:0] rk_next;
  logic [127:0] s_next;

  // PRESENT 4-bit S-box.
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Substitution layer: same S-box on all 32 nibbles of the state.
  for (genvar i = 0; i < 32; i++) begin : g_sbox
    assign sbox_out[4*i +: 4] = sbox4(state_q[4*i +: 4]);
  end

  // Round function: key schedule and data path both rotate left by 8 bits;
  // the round index is folded into the low nibble of the round key.
  assign rk_next = {rkey_q[119:0], rkey_q[127:120]} ^ {124'b0, rnd_q};
  assign s_next  = {sbox_out[119:0], sbox_out[127:120]} ^ rk_next;

  // Next-state logic for the IDLE/RUN controller and datapath registers.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (load_i) begin
          state_d = data_i ^ key_i;
          rkey_d  = key_i;
          rnd_d   = 4'd1;
          fsm_d   = RUN;
        end
      end
      default: begin
        if (rnd_q == LAST_RND) begin
          // Publish the result and scrub key material before going idle.
          data_d  = s_next;
          done_d  = 1'b1;
          state_d = '0;
          rkey_d  = '0;
          rnd_d   = 4'd0;
          fsm_d   = IDLE;
        end else begin
          state_d = s_next;
          rkey_d  = rk_next;
          rnd_d   = rnd_q + 4'd1;
        end
      end
    endcase
  end

  // State registers; reset clears everything immediately, aborting any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= 4'd0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign data_o  = data_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = done_q;
  assign round_o = rnd_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_round_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_round_core
// Purpose  : Directed self-checking bench for sbox_round_core at
//            pROUNDS = 1, 10 and 15.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_round_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- pROUNDS = 10 instance ----------------
  logic         load10 = 1'b0;
  logic [127:0] key10  = '0, data10 = '0, out10;
  logic         busy10, done10;
  logic [3:0]   rnd10;

  sbox_round_core #(.pROUNDS(10)) u_dut10 (
    .clk(clk), .rst(rst), .load_i(load10), .key_i(key10), .data_i(data10),
    .data_o(out10), .busy_o(busy10), .done_o(done10), .round_o(rnd10));

  // ---------------- pROUNDS = 1 instance ----------------
  logic         load1 = 1'b0;
  logic [127:0] key1  = '0, data1 = '0, out1;
  logic         busy1, done1;
  logic [3:0]   rnd1;

  sbox_round_core #(.pROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .load_i(load1), .key_i(key1), .data_i(data1),
    .data_o(out1), .busy_o(busy1), .done_o(done1), .round_o(rnd1));

  // ---------------- pROUNDS = 15 instance ----------------
  logic         load15 = 1'b0;
  logic [127:0] key15  = '0, data15 = '0, out15;
  logic         busy15, done15;
  logic [3:0]   rnd15;

  sbox_round_core #(.pROUNDS(15)) u_dut15 (
    .clk(clk), .rst(rst), .load_i(load15), .key_i(key15), .data_i(data15),
    .data_o(out15), .busy_o(busy15), .done_o(done15), .round_o(rnd15));

  // ---------------- reference model ----------------
  // S-box table, nibble v holds S(v).
  localparam logic [63:0] SB_TAB = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [127:0] rotl(input logic [127:0] v, input int n);
    logic [127:0] r;
    for (int b = 0; b < 128; b++) r[(b + n) % 128] = v[b];
    return r;
  endfunction

  function automatic logic [127:0] sub_all(input logic [127:0] v);
    logic [127:0] r;
    logic [63:0]  tab;
    tab = SB_TAB;
    for (int n = 0; n < 32; n++) r[4*n +: 4] = tab[4*int'(v[4*n +: 4]) +: 4];
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] d,
                                         input int rounds);
    logic [127:0] st, rk;
    st = d ^ k;
    rk = k;
    for (int r = 1; r <= rounds; r++) begin
      rk = rotl(rk, 8) ^ 128'(r);
      st = rotl(sub_all(st), 8) ^ rk;
    end
    return st;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [127:0] last10 = '0;

  // One pROUNDS=10 operation, sampled on negedges; optional stray load in round 3.
  task automatic op10(input logic [127:0] k, input logic [127:0] d, input bit inject);
    logic [127:0] exp;
    exp = model(k, d, 10);
    key10 = k; data10 = d; load10 = 1'b1;
    @(negedge clk);                       // after accepting edge E0
    load10 = 1'b0; key10 = rnd128(); data10 = rnd128();
    for (int i = 1; i <= 10; i++) begin
      chk("busy10_run", 128'(busy10), 128'(1));
      chk("round10", 128'(rnd10), 128'(i));
      chk("done10_run", 128'(done10), 128'(0));
      chk("data10_hold", out10, last10);
      if (inject && i == 3) begin
        load10 = 1'b1; key10 = rnd128(); data10 = rnd128();
      end
      @(negedge clk);
      load10 = 1'b0;
    end
    chk("busy10_end", 128'(busy10), 128'(0));
    chk("done10_pulse", 128'(done10), 128'(1));
    chk("round10_end", 128'(rnd10), 128'(0));
    chk("data10_result", out10, exp);
    last10 = exp;
    @(negedge clk);
    chk("done10_clear", 128'(done10), 128'(0));
    chk("busy10_idle", 128'(busy10), 128'(0));
  endtask

  initial begin
    logic [127:0] k, d, exp;
    logic [127:0] hk[5], hd[5];
    int waited;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_data", out10, 128'h0);
    chk("rst_busy", 128'(busy10), 128'(0));
    chk("rst_done", 128'(done10), 128'(0));
    chk("rst_round", 128'(rnd10), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // ---- pROUNDS=1, zero key and data: hand-computed CCC...CD ----
    load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    chk("p1_busy", 128'(busy1), 128'(1));
    chk("p1_round", 128'(rnd1), 128'(1));
    chk("p1_data_hold", out1, 128'h0);
    @(negedge clk);
    chk("p1_busy_end", 128'(busy1), 128'(0));
    chk("p1_done", 128'(done1), 128'(1));
    chk("p1_data", out1, 128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCD);
    @(negedge clk);
    chk("p1_done_clear", 128'(done1), 128'(0));
    chk("p1_data_keep", out1, 128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCD);

    // ---- pROUNDS=10: directed corner vectors, then ignored mid-run load ----
    op10('0, '0, 1'b0);
    op10({128{1'b1}}, '0, 1'b0);
    op10(128'h00010203_04050607_08090A0B_0C0D0E0F,
         128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);

    // ---- pROUNDS=10: random vectors ----
    for (int v = 0; v < 200; v++) op10(rnd128(), rnd128(), 1'b0);

    // ---- load held high for 5 operations: done every 11 cycles ----
    for (int j = 0; j < 5; j++) begin
      hk[j] = rnd128(); hd[j] = rnd128();
    end
    load10 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      key10 = hk[j]; data10 = hd[j];      // present at accepting edge
      @(negedge clk);
      key10 = rnd128(); data10 = rnd128();
      chk("hold_busy", 128'(busy10), 128'(1));
      repeat (9) begin
        @(negedge clk);
        chk("hold_nodone", 128'(done10), 128'(0));
      end
      @(negedge clk);
      chk("hold_done", 128'(done10), 128'(1));
      chk("hold_data", out10, model(hk[j], hd[j], 10));
      last10 = out10;
    end
    load10 = 1'b0;
    @(negedge clk);
    chk("hold_idle", 128'(busy10), 128'(0));

    // ---- async reset during round 5 ----
    key10 = rnd128(); data10 = rnd128(); load10 = 1'b1;
    @(negedge clk);
    load10 = 1'b0;
    waited = 0;
    while (rnd10 != 4'd5 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_reach_round5", 128'(rnd10), 128'(5));
    #1 rst = 1'b1;
    #1;                                   // still well before next posedge
    chk("arst_busy", 128'(busy10), 128'(0));
    chk("arst_done", 128'(done10), 128'(0));
    chk("arst_data", out10, 128'h0);
    chk("arst_round", 128'(rnd10), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    last10 = '0;
    @(negedge clk);
    chk("post_rst_nodone", 128'(done10), 128'(0));
    op10(rnd128(), rnd128(), 1'b0);

    // ---- pROUNDS=15 boundary: all-ones key, zero data ----
    k = {128{1'b1}}; d = '0;
    exp = model(k, d, 15);
    key15 = k; data15 = d; load15 = 1'b1;
    @(negedge clk);
    load15 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      chk("p15_busy", 128'(busy15), 128'(1));
      chk("p15_round", 128'(rnd15), 128'(i));
      @(negedge clk);
    end
    chk("p15_busy_end", 128'(busy15), 128'(0));
    chk("p15_done", 128'(done15), 128'(1));
    chk("p15_round_end", 128'(rnd15), 128'(0));
    chk("p15_data", out15, exp);
    @(negedge clk);
    chk("p15_done_clear", 128'(done15), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
